lc3_microsequencer: RTL and testbench
=====================================

# lc3_microsequencer

Microsequencer for the LC-3 control unit. It drives the read port of the 64 x 52-bit microcode control store and consumes each returned microinstruction. It computes the next microstate address from the IRD/COND/J fields and datapath condition inputs, and presents the datapath control signals for the current microstate. It sits between the control store and the datapath, replacing hard-wired state sequencing.

## Interface
- AddrBusSize, 6, control-store address width
- ElementSize, 52, microinstruction width
- CtrlWidth, 42, datapath control field width (microinstruction bits [41:0])
- INIT_STATE, 18, microstate entered after reset (LC-3 fetch)

- i_CLK  input  1  clock; all state updates on rising edge
- i_RST  input  1  synchronous, active-high reset
- i_stall  input  1  freeze sequencing for this cycle
- i_ir  input  16  instruction register; bits [15:12] used by IRD, bit [11] by COND 011
- i_ben  input  1  branch-enable condition
- i_r  input  1  memory-ready condition
- i_psr15  input  1  PSR privilege bit
- i_int  input  1  interrupt pending
- o_cs_read_en  output  1  control-store read enable
- o_cs_read_addr  output  AddrBusSize  control-store read address
- i_cs_read_data  input  ElementSize  control-store registered read data
- o_ctrl  output  CtrlWidth  datapath control signals of current microstate
- o_state  output  AddrBusSize  address of microinstruction currently on i_cs_read_data
- o_valid  output  1  i_cs_read_data holds a real microinstruction
- o_illegal  output  1  sticky: reserved COND value executed

## Operation
- Microinstruction fields: [51] IRD, [50:48] COND, [47:42] J, [41:0] control.
- FSM states:
  - RESET: held while i_RST = 1.
  - PRIME: one cycle after reset release.
  - RUN: normal sequencing.
- RESET -> PRIME on the first cycle with i_RST = 0. PRIME -> RUN unconditionally.
- PRIME: o_cs_read_en = 1, o_cs_read_addr = INIT_STATE, o_ctrl = 0, o_valid = 0.
- RUN, i_stall = 0:
  - o_cs_read_en = 1.
  - o_cs_read_addr = next address (computed below); cur_state <= next address.
- RUN, i_stall = 1:
  - o_cs_read_en = 1 and o_cs_read_addr = cur_state, so the same word is re-read.
  - cur_state is held and o_ctrl is forced to 0, so no control action repeats.
- Next address:
  - IRD = 1: next address = {2'b00, i_ir[15:12]}; COND and J are ignored.
  - IRD = 0: next address = J OR'd with one condition bit, selected by COND:
    - 000: J unchanged.
    - 001: J[1] |= i_r.
    - 010: J[2] |= i_ben.
    - 011: J[0] |= i_ir[11].
    - 100: J[3] |= i_psr15.
    - 101: J[4] |= i_int (see Configuration).
    - 110/111: reserved. Treated as 000, and o_illegal is set on that cycle's edge when not stalled.
- In RUN: o_ctrl = i_cs_read_data[41:0] (0 when stalled), o_state = cur_state, o_valid = 1.
- Condition inputs are sampled combinationally in the cycle the microinstruction is on i_cs_read_data.

## Timing
- Reset values while i_RST = 1:
  - o_cs_read_en = 0, o_cs_read_addr = 0, o_ctrl = 0.
  - o_state = INIT_STATE, o_valid = 0, o_illegal = 0.
  - FSM = RESET.
- The control store has one-cycle registered latency. An address presented in cycle t appears on i_cs_read_data in cycle t+1.
- Throughput is one microstate per cycle when not stalled.
- First valid microinstruction arrives 2 cycles after reset release: PRIME, then RUN with o_state = INIT_STATE.
- Path i_cs_read_data -> o_cs_read_addr is combinational; there are no internal pipeline bubbles.
- Reset mid-operation: the next edge returns every register to its reset value, and the in-flight read is discarded.
- A stall asserted during PRIME is ignored.
- Stall and IRD in the same cycle: the stall wins and IRD is evaluated after release.

## Configuration
- Macro: LC3_MICROSEQ_INT_EN.
- Defined: COND 101 ORs i_int into J[4].
- Undefined: COND 101 behaves as 000, i_int is unused, and COND 101 is not flagged illegal.

## Test plan
- Reset release:
  - First cycle after release: o_cs_read_addr = 18, o_cs_read_en = 1, o_valid = 0, o_ctrl = 0.
  - Next cycle: o_valid = 1, o_state = 18.
- IRD dispatch: word with IRD = 1 and i_ir[15:12] = 4'b0001 -> o_cs_read_addr = 1, then o_state = 1.
- Memory wait: COND = 001, J = 33.
  - i_r = 0 for 3 cycles -> address 33 each cycle, with o_ctrl repeated each cycle.
  - i_r = 1 -> address 35.
- Branch: COND = 010, J = 18.
  - i_ben = 1 -> 22.
  - i_ben = 0 -> 18.
- Stall: assert i_stall for 2 cycles in state 22.
  - During stall: o_cs_read_addr = 22, o_ctrl = 0, o_state = 22.
  - After release: o_ctrl = word(22) control field once, then the next address.
- Interrupt and illegal COND:
  - COND = 101, J = 1, i_int = 1 -> 17 with LC3_MICROSEQ_INT_EN defined, 1 without.
  - COND = 110 -> next address = J and o_illegal = 1, held until i_RST.

Source files
------------

// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: addresses the 64-word microcode store and picks the next microstate.
// Optional macro LC3_MICROSEQ_INT_EN enables COND 101 (interrupt test on J[4]).
module lc3_microsequencer #(
  parameter int AddrBusSize = 6,
  parameter int ElementSize = 52,
  parameter int CtrlWidth   = 42,
  parameter int INIT_STATE  = 18
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_stall,
  input  logic [15:0]            i_ir,
  input  logic                   i_ben,
  input  logic                   i_r,
  input  logic                   i_psr15,
  input  logic                   i_int,
  output logic                   o_cs_read_en,
  output logic [AddrBusSize-1:0] o_cs_read_addr,
  input  logic [ElementSize-1:0] i_cs_read_data,
  output logic [CtrlWidth-1:0]   o_ctrl,
  output logic [AddrBusSize-1:0] o_state,
  output logic                   o_valid,
  output logic                   o_illegal
);

  typedef enum logic [1:0] {ST_RESET, ST_PRIME, ST_RUN} fsm_e;

  localparam logic [AddrBusSize-1:0] InitAddr = AddrBusSize'(INIT_STATE);

  fsm_e                   fsm_q, fsm_d;
  logic [AddrBusSize-1:0] cur_state_q, cur_state_d;
  logic                   illegal_q, illegal_d;

  logic                   ird;
  logic [2:0]             cond;
  logic [AddrBusSize-1:0] j_field;
  logic [AddrBusSize-1:0] cond_mask;
  logic                   cond_illegal;
  logic [AddrBusSize-1:0] next_addr;

  assign ird     = i_cs_read_data[ElementSize-1];
  assign cond    = i_cs_read_data[ElementSize-2 -: 3];
  assign j_field = i_cs_read_data[CtrlWidth +: AddrBusSize];

`ifdef LC3_MICROSEQ_INT_EN
  logic unused_bits;
  assign unused_bits = ^i_ir[10:0];
`else
  logic unused_bits;
  assign unused_bits = ^{i_ir[10:0], i_int};
`endif

  // Next microaddress: IRD dispatches on the opcode, otherwise J with one condition bit OR'd in.
  always_comb begin
    cond_mask    = '0;
    cond_illegal = 1'b0;
    case (cond)
      3'b001: cond_mask[1] = i_r;
      3'b010: cond_mask[2] = i_ben;
      3'b011: cond_mask[0] = i_ir[11];
      3'b100: cond_mask[3] = i_psr15;
`ifdef LC3_MICROSEQ_INT_EN
      3'b101: cond_mask[4] = i_int;
`endif
      3'b110, 3'b111: cond_illegal = 1'b1;
      default: cond_mask = '0;
    endcase
    next_addr = ird ? AddrBusSize'(i_ir[15:12]) : (j_field | cond_mask);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      fsm_q       <= ST_RESET;
      cur_state_q <= InitAddr;
      illegal_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cur_state_q <= cur_state_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    cur_state_d = cur_state_q;
    illegal_d   = illegal_q;
    case (fsm_q)
      ST_RESET: fsm_d = ST_PRIME;
      ST_PRIME: begin
        fsm_d       = ST_RUN;
        cur_state_d = InitAddr;
      end
      ST_RUN: begin
        // A stalled cycle neither advances nor records an illegal COND.
        if (!i_stall) begin
          cur_state_d = next_addr;
          if (!ird && cond_illegal) illegal_d = 1'b1;
        end
      end
      default: fsm_d = ST_RESET;
    endcase
  end

  // Reset overrides outputs immediately so a mid-operation reset is visible in the same cycle.
  always_comb begin
    o_cs_read_en   = 1'b0;
    o_cs_read_addr = '0;
    o_ctrl         = '0;
    o_valid        = 1'b0;
    o_state        = cur_state_q;
    o_illegal      = illegal_q;
    if (i_RST) begin
      o_state   = InitAddr;
      o_illegal = 1'b0;
    end else begin
      case (fsm_q)
        ST_PRIME: begin
          o_cs_read_en   = 1'b1;
          o_cs_read_addr = InitAddr;
        end
        ST_RUN: begin
          o_cs_read_en   = 1'b1;
          o_valid        = 1'b1;
          o_cs_read_addr = i_stall ? cur_state_q : next_addr;
          o_ctrl         = i_stall ? '0 : i_cs_read_data[CtrlWidth-1:0];
        end
        default: o_cs_read_en = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_microsequencer.sv
// Bench for lc3_microsequencer: behavioural control store, vector table, and corner sequences.
module tb_lc3_microsequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [15:0] ir;
  logic        ben, r, psr15, intr;
  logic        cs_en;
  logic [5:0]  cs_addr;
  logic [51:0] cs_data = '0;
  logic [41:0] ctrl;
  logic [5:0]  st;
  logic        valid, illegal;

  int total = 0;
  int bad   = 0;

  logic [51:0] cs_mem [64];

  always #5 clk = ~clk;

  always @(posedge clk) if (cs_en) cs_data <= cs_mem[cs_addr];

  lc3_microsequencer dut (
    .i_CLK(clk), .i_RST(rst), .i_stall(stall), .i_ir(ir), .i_ben(ben), .i_r(r),
    .i_psr15(psr15), .i_int(intr), .o_cs_read_en(cs_en), .o_cs_read_addr(cs_addr),
    .i_cs_read_data(cs_data), .o_ctrl(ctrl), .o_state(st), .o_valid(valid),
    .o_illegal(illegal)
  );

  function automatic logic [41:0] ctrl_of(input logic [5:0] a);
    return {a, 30'h1555_5555, a};
  endfunction

  function automatic logic [51:0] mkword(input logic ird_b, input logic [2:0] c,
                                         input logic [5:0] j, input logic [5:0] a);
    return {ird_b, c, j, ctrl_of(a)};
  endfunction

  typedef struct {
    logic        stall;
    logic [15:0] ir;
    logic        ben, r, psr, intr;
    logic [5:0]  addr;
    logic [5:0]  st;
    logic        valid;
    logic        ctrl_zero;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic s, input logic [15:0] i, input logic b, input logic rr,
                              input logic p, input logic n, input logic [5:0] a,
                              input logic [5:0] sv, input logic v, input logic cz);
    vec_t t;
    t.stall = s; t.ir = i; t.ben = b; t.r = rr; t.psr = p; t.intr = n;
    t.addr = a; t.st = sv; t.valid = v; t.ctrl_zero = cz;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [15:0] i, input logic b, input logic rr,
                       input logic p, input logic n);
    stall = s; ir = i; ben = b; r = rr; psr15 = p; intr = n;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " en"}, 64'(cs_en), 64'd0);
    chk({tag, " addr"}, 64'(cs_addr), 64'd0);
    chk({tag, " ctrl"}, 64'(ctrl), 64'd0);
    chk({tag, " state"}, 64'(st), 64'd18);
    chk({tag, " valid"}, 64'(valid), 64'd0);
    chk({tag, " illegal"}, 64'(illegal), 64'd0);
  endtask

  initial begin
    logic [5:0] int_target;
    for (int a = 0; a < 64; a++) cs_mem[a] = mkword(1'b0, 3'b000, 6'(a), 6'(a));
    cs_mem[18] = mkword(1'b1, 3'b010, 6'd63, 6'd18);
    cs_mem[1]  = mkword(1'b0, 3'b001, 6'd33, 6'd1);
    cs_mem[33] = mkword(1'b0, 3'b001, 6'd33, 6'd33);
    cs_mem[35] = mkword(1'b0, 3'b010, 6'd18, 6'd35);
    cs_mem[22] = mkword(1'b0, 3'b000, 6'd35, 6'd22);
    cs_mem[5]  = mkword(1'b0, 3'b011, 6'd40, 6'd5);
    cs_mem[41] = mkword(1'b0, 3'b100, 6'd0, 6'd41);
    cs_mem[8]  = mkword(1'b0, 3'b100, 6'd16, 6'd8);
    cs_mem[16] = mkword(1'b0, 3'b001, 6'd20, 6'd16);
    cs_mem[6]  = mkword(1'b0, 3'b101, 6'd1, 6'd6);
    cs_mem[7]  = mkword(1'b0, 3'b110, 6'd9, 6'd7);
    cs_mem[9]  = mkword(1'b0, 3'b111, 6'd10, 6'd9);
    cs_mem[10] = mkword(1'b0, 3'b000, 6'd10, 6'd10);

    //            stall ir        ben r psr int  addr st valid cz
    vecs[0]  = mk(0, 16'h0000, 0, 0, 0, 0, 18, 18, 0, 1);
    vecs[1]  = mk(0, 16'h1000, 0, 0, 0, 0,  1, 18, 1, 0);
    vecs[2]  = mk(0, 16'h0000, 0, 0, 0, 0, 33,  1, 1, 0);
    vecs[3]  = mk(0, 16'h0000, 0, 0, 0, 0, 33, 33, 1, 0);
    vecs[4]  = mk(0, 16'h0000, 0, 0, 0, 0, 33, 33, 1, 0);
    vecs[5]  = mk(0, 16'h0000, 0, 0, 0, 0, 33, 33, 1, 0);
    vecs[6]  = mk(0, 16'h0000, 0, 1, 0, 0, 35, 33, 1, 0);
    vecs[7]  = mk(0, 16'h0000, 1, 0, 0, 0, 22, 35, 1, 0);
    vecs[8]  = mk(1, 16'h0000, 0, 0, 0, 0, 22, 22, 1, 1);
    vecs[9]  = mk(1, 16'h0000, 0, 0, 0, 0, 22, 22, 1, 1);
    vecs[10] = mk(0, 16'h0000, 0, 0, 0, 0, 35, 22, 1, 0);
    vecs[11] = mk(0, 16'h0000, 0, 0, 0, 0, 18, 35, 1, 0);
    vecs[12] = mk(1, 16'h5800, 0, 0, 0, 0, 18, 18, 1, 1);
    vecs[13] = mk(0, 16'h5800, 0, 0, 0, 0,  5, 18, 1, 0);
    vecs[14] = mk(0, 16'h0800, 0, 0, 0, 0, 41,  5, 1, 0);
    vecs[15] = mk(0, 16'h0000, 0, 0, 1, 0,  8, 41, 1, 0);
    vecs[16] = mk(0, 16'h0000, 0, 0, 0, 0, 16,  8, 1, 0);
    vecs[17] = mk(0, 16'h0800, 1, 1, 1, 1, 22, 16, 1, 0);
    vecs[18] = mk(0, 16'h0800, 1, 1, 1, 1, 35, 22, 1, 0);
    vecs[19] = mk(0, 16'h0800, 0, 1, 1, 1, 18, 35, 1, 0);

    rst = 1'b1;
    drive(0, 16'h0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1 chk_reset_outs("reset");

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].ir, vecs[i].ben, vecs[i].r, vecs[i].psr, vecs[i].intr);
      #1;
      chk($sformatf("row%0d en", i), 64'(cs_en), 64'd1);
      chk($sformatf("row%0d addr", i), 64'(cs_addr), 64'(vecs[i].addr));
      chk($sformatf("row%0d state", i), 64'(st), 64'(vecs[i].st));
      chk($sformatf("row%0d valid", i), 64'(valid), 64'(vecs[i].valid));
      chk($sformatf("row%0d ctrl", i), 64'(ctrl),
          vecs[i].ctrl_zero ? 64'd0 : 64'(ctrl_of(vecs[i].st)));
      chk($sformatf("row%0d illegal", i), 64'(illegal), 64'd0);
    end

    // COND 101 interrupt test, then a mid-operation reset
`ifdef LC3_MICROSEQ_INT_EN
    int_target = 6'd17;
`else
    int_target = 6'd1;
`endif
    @(negedge clk); drive(0, 16'h6000, 0, 0, 0, 0); #1;
    chk("ird6 addr", 64'(cs_addr), 64'd6);
    chk("ird6 state", 64'(st), 64'd18);
    @(negedge clk); drive(0, 16'h0000, 0, 0, 0, 1); #1;
    chk("cond101 addr", 64'(cs_addr), 64'(int_target));
    chk("cond101 state", 64'(st), 64'd6);
    chk("cond101 ctrl", 64'(ctrl), 64'(ctrl_of(6'd6)));
    @(negedge clk); drive(0, 16'h0000, 0, 0, 0, 0); #1;
    chk("cond101 not illegal", 64'(illegal), 64'd0);
    chk("cond101 landed", 64'(st), 64'(int_target));
    rst = 1'b1; #1;
    chk_reset_outs("midrst comb");
    @(negedge clk); #1;
    chk_reset_outs("midrst edge");

    // Stall during PRIME is ignored; reserved COND sets sticky illegal only when not stalled
    @(negedge clk); rst = 1'b0; drive(1, 16'h0000, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("prime2 addr", 64'(cs_addr), 64'd18);
    chk("prime2 valid", 64'(valid), 64'd0);
    chk("prime2 ctrl", 64'(ctrl), 64'd0);
    @(negedge clk); drive(0, 16'h7000, 0, 0, 0, 0); #1;
    chk("run2 state", 64'(st), 64'd18);
    chk("run2 valid", 64'(valid), 64'd1);
    chk("run2 addr", 64'(cs_addr), 64'd7);
    @(negedge clk); drive(1, 16'h0000, 0, 0, 0, 0); #1;
    chk("ill stall addr", 64'(cs_addr), 64'd7);
    chk("ill stall ctrl", 64'(ctrl), 64'd0);
    @(negedge clk); drive(0, 16'h0000, 0, 0, 0, 0); #1;
    chk("ill after stall", 64'(illegal), 64'd0);
    chk("cond110 addr", 64'(cs_addr), 64'd9);
    chk("cond110 ctrl", 64'(ctrl), 64'(ctrl_of(6'd7)));
    @(negedge clk); #1;
    chk("ill set", 64'(illegal), 64'd1);
    chk("cond111 state", 64'(st), 64'd9);
    chk("cond111 addr", 64'(cs_addr), 64'd10);
    @(negedge clk); drive(1, 16'h0000, 0, 0, 0, 0); #1;
    chk("ill held stall", 64'(illegal), 64'd1);
    chk("state10", 64'(st), 64'd10);
    @(negedge clk); drive(0, 16'h0000, 0, 0, 0, 0); #1;
    chk("ill held", 64'(illegal), 64'd1);
    chk("loop10 addr", 64'(cs_addr), 64'd10);
    rst = 1'b1;
    @(negedge clk); #1;
    chk_reset_outs("final rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
